// File: rtl/alu_pkg.sv
// Shared ALU op codes and the ID/EX control bundle for the MIPS execute stage.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned REG_W    = 5;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic                regwrite;
        logic                memwrite;
        logic                memtoreg;
        logic                alusrc;
        logic                bitshift;
        logic                jumpreg;
        logic [ALU_OP_W-1:0] alucontrol;
    } idex_ctrl_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic, wrapping add/sub, shifts of a by shamt, signed set-less-than.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [ALU_OP_W-1:0] op,
    output logic [WIDTH-1:0]    result,
    output logic                zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = WIDTH'($signed(a) >>> shamt);
            ALU_SLT: result = WIDTH'($signed(a) < $signed(b));
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register with valid/ready handshake, ALU and jr redirect.
module ex_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    output logic                ex_ready,
    input  logic                flush,
    input  logic [ALU_OP_W-1:0] alucontrol,
    input  logic                bitshift,
    input  logic                jumpreg,
    input  logic                alusrc,
    input  logic                regwrite_in,
    input  logic                memwrite_in,
    input  logic                memtoreg_in,
    input  logic [WIDTH-1:0]    srca,
    input  logic [WIDTH-1:0]    srcb,
    input  logic [WIDTH-1:0]    imm,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [REG_W-1:0]    writereg_in,
    input  logic [WIDTH-1:0]    pcplus4_in,
    output logic                ex_valid,
    input  logic                mem_ready,
    output logic [WIDTH-1:0]    aluresult,
    output logic                zero,
    output logic [WIDTH-1:0]    writedata,
    output logic                regwrite,
    output logic                memwrite,
    output logic                memtoreg,
    output logic [REG_W-1:0]    writereg,
    output logic [WIDTH-1:0]    pcplus4,
    output logic                jr_valid,
    output logic [WIDTH-1:0]    jr_target
);

    logic               occupied_q, occupied_d;
    idex_ctrl_t         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   srca_q, srcb_q, imm_q, pcplus4_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [REG_W-1:0]   writereg_q;
    logic               accept;
    logic               is_shift;
    logic [WIDTH-1:0]   alu_a, alu_b;
    logic [SHAMT_W-1:0] alu_sh;

    assign ex_ready = !occupied_q || mem_ready;
    assign accept   = id_valid && ex_ready && !flush;

    assign ctrl_d = '{regwrite:   regwrite_in,
                      memwrite:   memwrite_in,
                      memtoreg:   memtoreg_in,
                      alusrc:     alusrc,
                      bitshift:   bitshift,
                      jumpreg:    jumpreg,
                      alucontrol: alucontrol};

    // Flush beats accept, accept beats a plain departure.
    always_comb begin
        occupied_d = occupied_q;
        if (flush) begin
            occupied_d = 1'b0;
        end else if (accept) begin
            occupied_d = 1'b1;
        end else if (occupied_q && mem_ready) begin
            occupied_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupied_q <= 1'b0;
            ctrl_q     <= '0;
            srca_q     <= '0;
            srcb_q     <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            writereg_q <= '0;
            pcplus4_q  <= '0;
        end else begin
            occupied_q <= occupied_d;
            if (accept) begin
                ctrl_q     <= ctrl_d;
                srca_q     <= srca;
                srcb_q     <= srcb;
                imm_q      <= imm;
                shamt_q    <= shamt;
                writereg_q <= writereg_in;
                pcplus4_q  <= pcplus4_in;
            end
        end
    end

    // Shifts operate on rt; the count comes from shamt or from rs[4:0] for variable shifts.
    assign is_shift = (ctrl_q.alucontrol == ALU_SLL) ||
                      (ctrl_q.alucontrol == ALU_SRL) ||
                      (ctrl_q.alucontrol == ALU_SRA);
    assign alu_a    = is_shift ? srcb_q : srca_q;
    assign alu_b    = ctrl_q.alusrc ? imm_q : srcb_q;
    assign alu_sh   = ctrl_q.bitshift ? shamt_q : srca_q[SHAMT_W-1:0];

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .shamt  (alu_sh),
        .op     (ctrl_q.alucontrol),
        .result (aluresult),
        .zero   (zero)
    );

    assign ex_valid  = occupied_q;
    assign writedata = srcb_q;
    assign regwrite  = occupied_q && ctrl_q.regwrite;
    assign memwrite  = occupied_q && ctrl_q.memwrite;
    assign memtoreg  = occupied_q && ctrl_q.memtoreg;
    assign writereg  = writereg_q;
    assign pcplus4   = pcplus4_q;
    assign jr_valid  = occupied_q && ctrl_q.jumpreg && mem_ready && !flush;
    assign jr_target = srca_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expectations, a monitor checks departures.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, flush, mem_ready;
    logic        ex_ready, ex_valid, zero, regwrite, memwrite, memtoreg, jr_valid;
    logic [2:0]  alucontrol;
    logic        bitshift, jumpreg, alusrc, regwrite_in, memwrite_in, memtoreg_in;
    logic [31:0] srca, srcb, imm, pcplus4_in;
    logic [4:0]  shamt, writereg_in, writereg;
    logic [31:0] aluresult, writedata, pcplus4, jr_target;

    ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .ex_ready(ex_ready), .flush(flush),
        .alucontrol(alucontrol), .bitshift(bitshift), .jumpreg(jumpreg), .alusrc(alusrc),
        .regwrite_in(regwrite_in), .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
        .srca(srca), .srcb(srcb), .imm(imm), .shamt(shamt), .writereg_in(writereg_in),
        .pcplus4_in(pcplus4_in), .ex_valid(ex_valid), .mem_ready(mem_ready),
        .aluresult(aluresult), .zero(zero), .writedata(writedata), .regwrite(regwrite),
        .memwrite(memwrite), .memtoreg(memtoreg), .writereg(writereg), .pcplus4(pcplus4),
        .jr_valid(jr_valid), .jr_target(jr_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] pc;
        logic        jr;
        logic [31:0] tgt;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   jr_cnt = 0;
    logic b2b = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", nm, act, req, $time);
        end
    endfunction

    // Monitor: pop and compare on every departure; flushed or reset entries are discarded.
    always @(negedge clk) begin
        exp_t e;
        if (jr_valid) jr_cnt++;
        if (reset) begin
            sbq.delete();
        end else if (ex_valid && flush) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else if (ex_valid && mem_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_departure", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("aluresult", aluresult, e.res);
                chk("zero", 32'(zero), 32'(e.z));
                chk("regwrite", 32'(regwrite), 32'(e.rw));
                chk("writereg", 32'(writereg), 32'(e.wr));
                chk("pcplus4", pcplus4, e.pc);
                chk("jr_valid", 32'(jr_valid), 32'(e.jr));
                if (e.jr) chk("jr_target", jr_target, e.tgt);
            end
        end
    end

    task automatic set_in(input logic [2:0] op, input logic bs, input logic jrg, input logic asrc,
                          input logic rw, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [4:0] sh, input logic [4:0] wr);
        id_valid    = 1'b1;
        alucontrol  = op;
        bitshift    = bs;
        jumpreg     = jrg;
        alusrc      = asrc;
        regwrite_in = rw;
        memwrite_in = 1'b0;
        memtoreg_in = 1'b0;
        srca        = a;
        srcb        = b;
        imm         = im;
        shamt       = sh;
        writereg_in = wr;
        pcplus4_in  = 32'h0040_0000 + {25'd0, wr, 2'b00};
    endtask

    // Present one instruction, push its expectation on the accepting edge, return at posedge+1.
    task automatic send(input logic [2:0] op, input logic bs, input logic jrg, input logic asrc,
                        input logic rw, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [4:0] sh, input logic [4:0] wr,
                        input logic [31:0] res, input logic z);
        exp_t e;
        bit   acc = 1'b0;
        set_in(op, bs, jrg, asrc, rw, a, b, im, sh, wr);
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            if (b2b && c == 0) chk("no_bubble", 32'(ex_valid), 32'd1);
            if (ex_ready && !flush) begin
                e.res = res; e.z = z; e.rw = rw; e.wr = wr; e.jr = jrg; e.tgt = a;
                e.pc  = 32'h0040_0000 + {25'd0, wr, 2'b00};
                sbq.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        id_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int jr0;
        reset = 1'b1; flush = 1'b0; mem_ready = 1'b1;
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        id_valid = 1'b0;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_jr_valid", 32'(jr_valid), 32'd0);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_pcplus4", pcplus4, 32'd0);
        chk("rst_aluresult", aluresult, 32'd0);
        @(posedge clk); #1;

        // Back-to-back ALU vectors at full throughput
        send(3'b010, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'h0000_0001, 32'd0, 5'd0, 5'd1, 32'h8000_0000, 0);
        b2b = 1'b1;
        send(3'b011, 0, 0, 0, 1, 32'd5, 32'd5, 32'd0, 5'd0, 5'd2, 32'd0, 1);
        send(3'b110, 1, 0, 0, 1, 32'd0, 32'h8000_0010, 32'd0, 5'd4, 5'd3, 32'hF800_0001, 0);
        send(3'b101, 1, 0, 0, 1, 32'd0, 32'h8000_0010, 32'd0, 5'd4, 5'd4, 32'h0800_0001, 0);
        send(3'b111, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 5'd5, 32'd1, 0);
        send(3'b000, 0, 0, 1, 1, 32'hF0F0_F0F0, 32'd0, 32'h0FF0_0FF0, 5'd0, 5'd6, 32'h00F0_00F0, 0);
        send(3'b001, 0, 0, 0, 1, 32'h1234_0000, 32'h0000_5678, 32'd0, 5'd0, 5'd7, 32'h1234_5678, 0);
        send(3'b100, 0, 0, 0, 1, 32'h0000_0108, 32'd1, 32'd0, 5'd31, 5'd8, 32'h0000_0100, 0);
        b2b = 1'b0;
        tick(2);

        // Stall with a waiting instruction, then resume back-to-back
        send(3'b010, 0, 0, 0, 1, 32'd10, 32'd20, 32'd0, 5'd0, 5'd9, 32'd30, 0);
        mem_ready = 1'b0;
        set_in(3'b011, 0, 0, 0, 1, 32'd9, 32'd4, 32'd0, 5'd0, 5'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ex_ready", 32'(ex_ready), 32'd0);
            chk("stall_aluresult", aluresult, 32'd30);
            chk("stall_writereg", 32'(writereg), 32'd9);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        b2b = 1'b1;
        send(3'b011, 0, 0, 0, 1, 32'd9, 32'd4, 32'd0, 5'd0, 5'd10, 32'd5, 0);
        send(3'b010, 0, 0, 1, 1, 32'd1, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd11, 32'd0, 1);
        b2b = 1'b0;
        tick(2);

        // jr stalled two cycles must pulse exactly once
        send(3'b010, 0, 1, 0, 0, 32'h0040_0020, 32'd0, 32'd0, 5'd0, 5'd12, 32'h0040_0020, 0);
        mem_ready = 1'b0;
        jr0 = jr_cnt;
        tick(2);
        mem_ready = 1'b1;
        tick(3);
        chk("jr_pulse_count", 32'(jr_cnt - jr0), 32'd1);

        // Flush while occupied by a jr, with a new instruction offered
        send(3'b010, 0, 1, 0, 1, 32'h0000_1234, 32'd0, 32'd0, 5'd0, 5'd13, 32'h0000_1234, 0);
        mem_ready = 1'b0;
        tick(1);
        jr0 = jr_cnt;
        mem_ready = 1'b1;
        flush = 1'b1;
        set_in(3'b001, 0, 0, 0, 1, 32'd1, 32'd2, 32'd0, 5'd0, 5'd14);
        @(negedge clk);
        chk("flush_jr_suppressed", 32'(jr_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_regwrite", 32'(regwrite), 32'd0);
        chk("flush_jr_valid", 32'(jr_valid), 32'd0);
        @(posedge clk); #1;
        chk("flush_jr_count", 32'(jr_cnt - jr0), 32'd0);

        // Reset during a stall
        send(3'b010, 0, 1, 0, 1, 32'd3, 32'd4, 32'd0, 5'd0, 5'd15, 32'd7, 0);
        mem_ready = 1'b0;
        tick(1);
        reset = 1'b1;
        flush = 1'b1;
        set_in(3'b010, 0, 0, 0, 1, 32'd1, 32'd1, 32'd0, 5'd0, 5'd16);
        tick(1);
        reset = 1'b0;
        flush = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);
        chk("rst2_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst2_regwrite", 32'(regwrite), 32'd0);
        chk("rst2_jr_valid", 32'(jr_valid), 32'd0);
        chk("rst2_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst2_writereg", 32'(writereg), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        tick(2);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
